// File: rtl/pls_keycode_pkg.sv
// Shared constants for the keycode FIFO: register map, status bit positions, control bits.
package pls_keycode_pkg;

    typedef enum logic [1:0] {
        KC_ADDR_DATA   = 2'd0,
        KC_ADDR_STATUS = 2'd1,
        KC_ADDR_CTRL   = 2'd2,
        KC_ADDR_INFO   = 2'd3
    } kc_addr_e;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 16;

    localparam int CTL_FLUSH   = 0;
    localparam int CTL_CLR_OVF = 1;

    // INFO word lets software discover the build-time geometry.
    function automatic logic [31:0] kc_info_word(input int data_w, input int depth);
        return {16'(data_w), 16'(depth)};
    endfunction

endpackage

// File: rtl/pls_keycode_fifo_if.sv
// Avalon-MM slave signals plus the consumer-side keycode/strobe/ack bundle.
interface pls_keycode_fifo_if #(
    parameter int DATA_W = 8
);
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [DATA_W-1:0] out_port;
    logic              out_valid;
    logic              out_ack;

    modport slave (
        input  address, chipselect, write_n, writedata, out_ack,
        output readdata, out_port, out_valid
    );

    modport master (
        output address, chipselect, write_n, writedata, out_ack,
        input  readdata, out_port, out_valid
    );
endinterface

// File: rtl/pls_sync_fifo.sv
// Single-clock FIFO with occupancy count; flush clears pointers and count but not storage.
module pls_sync_fifo #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 8,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = AW + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] head_o,
    output logic [CW-1:0]     count_o,
    output logic              full_o,
    output logic              empty_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_q, wr_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              pop_ok;
    logic              push_ok;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    // A full FIFO still accepts a push when the same edge frees a slot.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_ok) wr_d = wr_q + AW'(1);
            if (pop_ok)  rd_d = rd_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && push_ok && !flush_i) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/pls_keycode_fifo.sv
// Keycode FIFO peripheral: Avalon-MM push/status/control, head keycode with valid strobe and ack pop.
module pls_keycode_fifo
    import pls_keycode_pkg::*;
#(
    parameter  int DATA_W    = 8,
    parameter  int DEPTH     = 8,
    parameter  int HOLD_LAST = 1,
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    pls_keycode_fifo_if.slave  bus
);
    logic              sel_wr;
    logic              push;
    logic              ctrl_wr;
    logic              flush;
    logic              clr_ovf;
    logic              pop;
    logic              drop;
    logic [DATA_W-1:0] head;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [31:0]       data_word;
    logic [31:0]       status_word;
    logic              unused_wdata;

    assign sel_wr  = bus.chipselect & ~bus.write_n;
    assign push    = sel_wr & (kc_addr_e'(bus.address) == KC_ADDR_DATA);
    assign ctrl_wr = sel_wr & (kc_addr_e'(bus.address) == KC_ADDR_CTRL);
    assign flush   = ctrl_wr & bus.writedata[CTL_FLUSH];
    assign clr_ovf = ctrl_wr & bus.writedata[CTL_CLR_OVF];

    assign bus.out_valid = ~empty;
    assign pop           = bus.out_ack & bus.out_valid;
    // A push lost to flush is a deliberate discard, not an overflow.
    assign drop          = push & full & ~pop & ~flush;

    assign unused_wdata = ^bus.writedata;

    pls_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .wdata_i (bus.writedata[DATA_W-1:0]),
        .pop_i   (pop),
        .flush_i (flush),
        .head_o  (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        ovf_d = ovf_q;
        if (drop)         ovf_d = 1'b1;
        else if (clr_ovf) ovf_d = 1'b0;
    end

    assign hold_d = (pop && !flush) ? head : hold_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ovf_q  <= 1'b0;
            hold_q <= '0;
        end else begin
            ovf_q  <= ovf_d;
            hold_q <= hold_d;
        end
    end

    assign bus.out_port = bus.out_valid ? head : ((HOLD_LAST != 0) ? hold_q : '0);

    always_comb begin
        data_word             = '0;
        data_word[DATA_W-1:0] = bus.out_port;
        data_word[31]         = bus.out_valid;
    end

    always_comb begin
        status_word                     = '0;
        status_word[ST_EMPTY]           = empty;
        status_word[ST_FULL]            = full;
        status_word[ST_OVF]             = ovf_q;
        status_word[ST_CNT_LSB +: CW]   = count;
    end

    always_comb begin
        bus.readdata = '0;
        case (kc_addr_e'(bus.address))
            KC_ADDR_DATA:   bus.readdata = data_word;
            KC_ADDR_STATUS: bus.readdata = status_word;
            KC_ADDR_CTRL:   bus.readdata = '0;
            KC_ADDR_INFO:   bus.readdata = kc_info_word(DATA_W, DEPTH);
            default:        bus.readdata = '0;
        endcase
    end

endmodule
